// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request, mthi/mtlo, shared-ALU and result signals of the multiply/divide sequencer.
// master: pipeline/ALU side (drives request, HI/LO write and alu_out).
// slave:  sequencer side (drives the ALU operands/op, busy, done, hi, lo).
interface mdu_seq_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (
    output start, md_op, rs_val, rt_val, hilo_we, hilo_sel, hilo_wdata, alu_out,
    input  alu_src1, alu_src2, alu_op, busy, done, hi, lo
  );
  modport slave (
    input  start, md_op, rs_val, rt_val, hilo_we, hilo_sel, hilo_wdata, alu_out,
    output alu_src1, alu_src2, alu_op, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle mult/multu/div/divu sequencer that borrows the shared ALU and owns HI/LO.
// Ports: clk; reset (sync, active-high); bus (mdu_seq_if.slave) carrying the request
//   (start, md_op, rs_val, rt_val), mthi/mtlo write (hilo_we, hilo_sel, hilo_wdata),
//   the shared ALU port (alu_src1/alu_src2/alu_op out, alu_out in) and busy, done, hi, lo.
// MDU_DIV_EN: define to build the divider; otherwise div/divu finish in one cycle with HI/LO unchanged.
module mdu_seq #(
  parameter int N_ITER = 32
) (
  input logic      clk,
  input logic      reset,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(N_ITER + 1);
  typedef enum logic [3:0] {IDLE, PRE_A, PRE_B, ITER_A, ITER_B, POST_A, POST_B, POST_C, DONE} state_t;
  state_t state_q, state_d;
  // h: H (mult) / R (div), l: L / Q, m: M / D, s: partial sum of the current multiply step
  logic [31:0] h_q, h_d, l_q, l_d, m_q, m_d, s_q, s_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] src1, src2, addend;
  logic [3:0]  op;
  logic [CW-1:0] cnt_q, cnt_d;
  // c: multiply carry-free flag reuse -> divide "lt" in ITER, low-word-zero in POST
  logic sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, c_q, c_d, dv;
`ifdef MDU_DIV_EN
  logic div_q, div_d, msb_q, msb_d;
  assign dv = div_q;
`else
  assign dv = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    l_d = l_q;
    m_d = m_q;
    s_d = s_q;
    hi_d = hi_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    sa_d = sa_q;
    sb_d = sb_q;
    c_d = c_q;
`ifdef MDU_DIV_EN
    div_d = div_q;
    msb_d = msb_q;
`endif
    src1 = '0;
    src2 = '0;
    op = 4'd0;
    addend = l_q[0] ? m_q : '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sgn_d = ~bus.md_op[0];
          sa_d = ~bus.md_op[0] & bus.rs_val[31];
          sb_d = ~bus.md_op[0] & bus.rt_val[31];
          cnt_d = '0;
          h_d = '0;
          s_d = '0;
          c_d = 1'b0;
          if (bus.md_op[1]) begin
`ifdef MDU_DIV_EN
            div_d = 1'b1;
            msb_d = 1'b0;
            l_d = bus.rs_val;
            m_d = bus.rt_val;
            if (bus.rt_val == '0) begin
              state_d = DONE;
              hi_d = bus.rs_val;
              lo_d = '1;
            end else begin
              state_d = bus.md_op[0] ? ITER_A : PRE_A;
            end
`else
            state_d = DONE;
`endif
          end else begin
`ifdef MDU_DIV_EN
            div_d = 1'b0;
`endif
            l_d = bus.rt_val;
            m_d = bus.rs_val;
            state_d = bus.md_op[0] ? ITER_A : PRE_A;
          end
        end else if (bus.hilo_we) begin
          if (bus.hilo_sel) hi_d = bus.hilo_wdata;
          else lo_d = bus.hilo_wdata;
        end
      end
      // PRE_A negates the rs operand, PRE_B the rt operand, each only if negative
      PRE_A: begin
        op = 4'd1;
        src2 = dv ? l_q : m_q;
        if (sa_q) begin
          if (dv) l_d = bus.alu_out;
          else m_d = bus.alu_out;
        end
        state_d = PRE_B;
      end
      PRE_B: begin
        op = 4'd1;
        src2 = dv ? m_q : l_q;
        if (sb_q) begin
          if (dv) m_d = bus.alu_out;
          else l_d = bus.alu_out;
        end
        state_d = ITER_A;
      end
      ITER_A: begin
`ifdef MDU_DIV_EN
        if (div_q) begin
          op = 4'd7;
          src1 = {h_q[30:0], l_q[31]};
          src2 = m_q;
          c_d = bus.alu_out[0];
          h_d = src1;
          msb_d = h_q[31];
          l_d = {l_q[30:0], 1'b0};
        end else
`endif
        begin
          src1 = h_q;
          src2 = addend;
          s_d = bus.alu_out;
        end
        state_d = ITER_B;
      end
      ITER_B: begin
`ifdef MDU_DIV_EN
        if (div_q) begin
          op = 4'd1;
          src1 = h_q;
          src2 = m_q;
          // 33-bit partial remainder {msb,R} >= D: subtract and set quotient bit
          if (msb_q | ~c_q) begin
            h_d = bus.alu_out;
            l_d[0] = 1'b1;
          end
        end else
`endif
        begin
          // sltu(S, addend) recovers the carry out of the ITER_A add
          op = 4'd7;
          src1 = s_q;
          src2 = addend;
          h_d = {bus.alu_out[0], s_q[31:1]};
          l_d = {s_q[0], l_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_ITER - 1)) state_d = sgn_q ? POST_A : DONE;
        else state_d = ITER_A;
      end
      // 64-bit negate of {H,L} is {~H + (L==0), 0-L}; divide negates Q here as well
      POST_A: begin
        op = 4'd1;
        src2 = l_q;
        if (sa_q ^ sb_q) begin
          l_d = bus.alu_out;
          c_d = l_q == '0;
        end
        state_d = POST_B;
      end
      POST_B: begin
        op = dv ? 4'd1 : 4'd5;
        src1 = dv ? '0 : h_q;
        src2 = dv ? h_q : '0;
        if (dv ? sa_q : sa_q ^ sb_q) h_d = bus.alu_out;
        state_d = POST_C;
      end
      POST_C: begin
        if (!dv) begin
          src1 = h_q;
          src2 = {31'b0, c_q};
          if (sa_q ^ sb_q) h_d = bus.alu_out;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q inside {ITER_B, POST_C} && state_d == DONE) begin
      hi_d = h_d;
      lo_d = l_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      h_q <= '0;
      l_q <= '0;
      m_q <= '0;
      s_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      c_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q <= 1'b0;
      msb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      l_q <= l_d;
      m_q <= m_d;
      s_q <= s_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      c_q <= c_d;
`ifdef MDU_DIV_EN
      div_q <= div_d;
      msb_q <= msb_d;
`endif
    end
  end
  assign bus.alu_src1 = src1;
  assign bus.alu_src2 = src2;
  assign bus.alu_op = op;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized self-checking bench for mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  mdu_seq_if bus();
  mdu_seq #(.N_ITER(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // shared ALU model
  always_comb begin
    case (bus.alu_op)
      4'd0: bus.alu_out = bus.alu_src1 + bus.alu_src2;
      4'd1: bus.alu_out = bus.alu_src1 - bus.alu_src2;
      4'd2: bus.alu_out = bus.alu_src1 | bus.alu_src2;
      4'd3: bus.alu_out = bus.alu_src1 & bus.alu_src2;
      4'd4: bus.alu_out = bus.alu_src1 ^ bus.alu_src2;
      4'd5: bus.alu_out = ~(bus.alu_src1 | bus.alu_src2);
      4'd6: bus.alu_out = {31'b0, $signed(bus.alu_src1) < $signed(bus.alu_src2)};
      4'd7: bus.alu_out = {31'b0, bus.alu_src1 < bus.alu_src2};
      4'd8: bus.alu_out = bus.alu_src1 << bus.alu_src2[4:0];
      4'd9: bus.alu_out = bus.alu_src1 >> bus.alu_src2[4:0];
      4'd10: bus.alu_out = $signed(bus.alu_src1) >>> bus.alu_src2[4:0];
      default: bus.alu_out = '0;
    endcase
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l, output int lat);
    logic [63:0] p;
    lat = op[0] ? 65 : 70;
    case (op)
      2'd0: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {h, l} = p;
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {h, l} = p;
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == '0) begin
          h = a;
          l = '1;
          lat = 1;
        end else if (op == 2'd3) begin
          l = a / b;
          h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = '0;
        end else begin
          l = $signed(a) / $signed(b);
          h = $signed(a) % $signed(b);
        end
`else
        lat = 1;
`endif
      end
    endcase
  endfunction
  // poke > 0: at that cycle of the operation, raise start and hilo_we, which must be ignored
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input int poke);
    int lat, exp_lat;
    logic [31:0] eh, el;
    eh = m_hi;
    el = m_lo;
    ref_op(op, a, b, eh, el, exp_lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.hilo_we = we;
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = ~a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hilo_we = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = lat == poke;
      bus.hilo_we = lat == poke;
      bus.hilo_sel = lat[0];
      bus.md_op = 2'd0;
      bus.hilo_wdata = 32'hDEAD_BEEF;
    end while (!bus.done && lat < 200);
    chk("done_seen", {63'b0, bus.done}, 64'd1);
    chk("latency", lat, exp_lat);
    chk("hi", bus.hi, eh);
    chk("lo", bus.lo, el);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk("done_pulse", {bus.done, bus.busy}, 2'b00);
  endtask
  task automatic mt(input logic sel, input logic [31:0] d);
    @(negedge clk);
    bus.hilo_we = 1'b1;
    bus.hilo_sel = sel;
    bus.hilo_wdata = d;
    @(posedge clk);
    #1;
    bus.hilo_we = 1'b0;
    if (sel) m_hi = d;
    else m_lo = d;
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask
  task automatic reset_mid;
    logic saw;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'd1;
    bus.rs_val = 32'h1234_5678;
    bus.rt_val = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("rst_busy_done", {bus.busy, bus.done}, 2'b00);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      saw |= bus.done;
    end
    chk("rst_no_done", {63'b0, saw}, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.md_op = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hilo_we = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {bus.busy, bus.done}, 2'b00);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_alu", {bus.alu_op, bus.alu_src1, bus.alu_src2}, 0);
    reset = 1'b0;
    mt(1'b0, 32'h0000_1234);
    mt(1'b1, 32'h0000_CAFE);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(2'd3, 32'd100, 32'd0, 1'b0, 0);
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 0);
    do_op(2'd3, 32'hFFFF_FFFF, 32'd3, 1'b0, 0);
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    do_op(2'd1, 32'h0001_0001, 32'h0000_FFFF, 1'b1, 0);
    do_op(2'd1, $urandom, $urandom, 1'b0, 10);
    do_op(2'd0, $urandom, $urandom, 1'b0, 40);
    reset_mid();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
